// File: rtl/ads8864_block_averager.sv
// Block averager for the ADS8864 sample stream: averages 2^n consecutive codes and
// writes {average, peak-to-peak span} into the sample RAM through a wrapping port.
module ads8864_block_averager #(
  parameter int MAX_LOG2N = 8,
  parameter int ADDR_W    = 10
) (
  input  logic              SYSCLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              CLEAR,
  input  logic [3:0]        CFG_LOG2N,
  input  logic [15:0]       SMP_DATA,
  input  logic              SMP_VALID,
  output logic [15:0]       AVG_DATA,
  output logic              AVG_VALID,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [31:0]       RAM_DI,
  output logic              WRAPPED,
  output logic              BUSY
);

  localparam int         ACC_W = 16 + MAX_LOG2N;
  localparam logic [3:0] MAX_N = 4'(MAX_LOG2N);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   accept;

  logic [ACC_W-1:0]       acc_q;
  logic [MAX_LOG2N-1:0]   cnt_q;
  logic [3:0]             n_q;
  logic [15:0]            min_q;
  logic [15:0]            max_q;
  logic [15:0]            avg_q;
  logic [31:0]            di_q;
  logic                   valid_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   wrap_q;

  logic                   first;
  logic [3:0]             eff_n;
  logic [MAX_LOG2N-1:0]   last_cnt;
  logic                   last;
  logic [ACC_W-1:0]       acc_base;
  logic [ACC_W-1:0]       sum;
  logic [15:0]            min_base;
  logic [15:0]            max_base;
  logic [15:0]            min_next;
  logic [15:0]            max_next;
  logic [15:0]            avg_next;
  logic [15:0]            span_next;

  always_ff @(posedge SYSCLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE) state_d = ACCUM;
      end
      ACCUM: begin
        if (!ENABLE) state_d = IDLE;
        else         accept  = SMP_VALID;
      end
      default: state_d = IDLE;
    endcase
  end

  // The block length is frozen on the first sample, so CFG_LOG2N only matters when cnt is 0.
  always_comb begin
    first     = (cnt_q == '0);
    eff_n     = first ? ((CFG_LOG2N > MAX_N) ? MAX_N : CFG_LOG2N) : n_q;
    last_cnt  = ~({MAX_LOG2N{1'b1}} << eff_n);
    last      = accept && (cnt_q == last_cnt);
    acc_base  = first ? '0 : acc_q;
    sum       = acc_base + {{MAX_LOG2N{1'b0}}, SMP_DATA};
    min_base  = first ? SMP_DATA : min_q;
    max_base  = first ? SMP_DATA : max_q;
    min_next  = (SMP_DATA < min_base) ? SMP_DATA : min_base;
    max_next  = (SMP_DATA > max_base) ? SMP_DATA : max_base;
    avg_next  = 16'(sum >> eff_n);
    span_next = max_next - min_next;
  end

  // The closing sample rewinds the counter on the same edge, so back-to-back blocks lose nothing.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      min_q   <= '0;
      max_q   <= '0;
      avg_q   <= '0;
      di_q    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
    end else if (CLEAR) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (valid_q) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (addr_q == '1) wrap_q <= 1'b1;
      end
      if (!ENABLE) begin
        acc_q <= '0;
        cnt_q <= '0;
        min_q <= '0;
        max_q <= '0;
      end else if (accept) begin
        n_q <= eff_n;
        if (last) begin
          acc_q   <= '0;
          cnt_q   <= '0;
          min_q   <= '0;
          max_q   <= '0;
          avg_q   <= avg_next;
          di_q    <= {avg_next, span_next};
          valid_q <= 1'b1;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + MAX_LOG2N'(1);
          min_q <= min_next;
          max_q <= max_next;
        end
      end
    end
  end

  assign AVG_DATA  = avg_q;
  assign AVG_VALID = valid_q;
  assign RAM_WE    = valid_q;
  assign RAM_ADDR  = addr_q;
  assign RAM_DI    = di_q;
  assign WRAPPED   = wrap_q;
  assign BUSY      = (cnt_q != '0);

endmodule

// File: tb/tb_ads8864_block_averager.sv
// Directed bench for ads8864_block_averager: a cycle table of hand-computed vectors
// followed by hand-written address-wrap, full-scale and length-clamp sequences.
module tb_ads8864_block_averager;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        CLEAR;
  logic [3:0]  CFG_LOG2N;
  logic [15:0] SMP_DATA;
  logic        SMP_VALID;
  logic [15:0] AVG_DATA;
  logic        AVG_VALID;
  logic        RAM_WE;
  logic [2:0]  RAM_ADDR;
  logic [31:0] RAM_DI;
  logic        WRAPPED;
  logic        BUSY;

  int n_compared   = 0;
  int n_mismatched = 0;

  ads8864_block_averager #(.MAX_LOG2N(8), .ADDR_W(3)) dut (
    .SYSCLK   (SYSCLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .CLEAR    (CLEAR),
    .CFG_LOG2N(CFG_LOG2N),
    .SMP_DATA (SMP_DATA),
    .SMP_VALID(SMP_VALID),
    .AVG_DATA (AVG_DATA),
    .AVG_VALID(AVG_VALID),
    .RAM_WE   (RAM_WE),
    .RAM_ADDR (RAM_ADDR),
    .RAM_DI   (RAM_DI),
    .WRAPPED  (WRAPPED),
    .BUSY     (BUSY)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic        rst;
    logic        en;
    logic        clr;
    logic [3:0]  n;
    logic [15:0] d;
    logic        vld;
    logic        e_we;
    logic [15:0] e_avg;
    logic [31:0] e_di;
    logic [2:0]  e_addr;
    logic        e_wrap;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic en, logic clr, logic [3:0] n, logic [15:0] d,
                              logic vld, logic e_we, logic [15:0] e_avg, logic [31:0] e_di,
                              logic [2:0] e_addr, logic e_wrap, logic e_busy);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.n = n; v.d = d; v.vld = vld;
    v.e_we = e_we; v.e_avg = e_avg; v.e_di = e_di; v.e_addr = e_addr;
    v.e_wrap = e_wrap; v.e_busy = e_busy;
    return v;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic rst, input logic en, input logic clr,
                               input logic [3:0] n, input logic [15:0] d, input logic vld);
    RESET = rst; ENABLE = en; CLEAR = clr; CFG_LOG2N = n; SMP_DATA = d; SMP_VALID = vld;
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] got,
                     input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_we, input logic [15:0] e_avg,
                             input logic [31:0] e_di, input logic [2:0] e_addr,
                             input logic e_wrap, input logic e_busy);
    cmp(name, "AVG_VALID", 32'(AVG_VALID), 32'(e_we));
    cmp(name, "RAM_WE", 32'(RAM_WE), 32'(e_we));
    cmp(name, "AVG_DATA", 32'(AVG_DATA), 32'(e_avg));
    if (e_we) cmp(name, "RAM_DI", RAM_DI, e_di);
    cmp(name, "RAM_ADDR", 32'(RAM_ADDR), 32'(e_addr));
    cmp(name, "WRAPPED", 32'(WRAPPED), 32'(e_wrap));
    cmp(name, "BUSY", 32'(BUSY), 32'(e_busy));
  endtask

  initial begin
    RESET = 1'b0; ENABLE = 1'b0; CLEAR = 1'b0; CFG_LOG2N = 4'd0; SMP_DATA = 16'd0; SMP_VALID = 1'b0;

    //                 rst en clr n  data   vld we avg       di            addr wr busy
    vecs.push_back(mk(1, 0, 0, 0, 0,     0, 0, 16'd0,   32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0,     0, 0, 16'd0,   32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 100,   1, 0, 16'd0,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 200,   1, 0, 16'd0,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 300,   1, 0, 16'd0,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 400,   1, 1, 16'd250, 32'h00FA012C, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 10,    1, 0, 16'd250, 32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 20,    1, 0, 16'd250, 32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 30,    1, 0, 16'd250, 32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 41,    1, 1, 16'd25,  32'h0019001F, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 3,     1, 0, 16'd25,  32'h0,        2, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 4,     1, 1, 16'd3,   32'h00030001, 2, 0, 0));
    // partial block abandoned by ENABLE=0, sample in IDLE ignored
    vecs.push_back(mk(0, 1, 0, 2, 1000,  1, 0, 16'd3,   32'h0,        3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 2000,  1, 0, 16'd3,   32'h0,        3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 2, 0,     0, 0, 16'd3,   32'h0,        3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2, 5,     1, 0, 16'd3,   32'h0,        3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0,     0, 0, 16'd3,   32'h0,        3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 4,     1, 0, 16'd3,   32'h0,        3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 8,     1, 0, 16'd3,   32'h0,        3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 12,    1, 0, 16'd3,   32'h0,        3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 16,    1, 1, 16'd10,  32'h000A000C, 3, 0, 0));
    // mid-block CFG_LOG2N change only affects the next block
    vecs.push_back(mk(0, 1, 0, 2, 1,     1, 0, 16'd10,  32'h0,        4, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 2,     1, 0, 16'd10,  32'h0,        4, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4, 3,     1, 0, 16'd10,  32'h0,        4, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4, 6,     1, 1, 16'd3,   32'h00030005, 4, 0, 0));
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk(0, 1, 0, 4, 16'(i * 16), 1, 0, 16'd3, 32'h0, 5, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4, 240,   1, 1, 16'd120, 32'h007800F0, 5, 0, 0));
    // CLEAR mid-block, with a final sample, and on the write cycle
    vecs.push_back(mk(0, 1, 0, 2, 50,    1, 0, 16'd120, 32'h0,        6, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 60,    1, 0, 16'd120, 32'h0,        6, 0, 1));
    vecs.push_back(mk(0, 1, 1, 2, 70,    1, 0, 16'd120, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1,     1, 0, 16'd120, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 2,     1, 0, 16'd120, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 3,     1, 0, 16'd120, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 5,     1, 1, 16'd2,   32'h00020004, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 8,     1, 0, 16'd2,   32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 8,     1, 0, 16'd2,   32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 8,     1, 0, 16'd2,   32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 2, 8,     1, 0, 16'd2,   32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 1,     1, 0, 16'd2,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 1,     1, 0, 16'd2,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 1,     1, 0, 16'd2,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 1,     1, 1, 16'd1,   32'h00010000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0,     0, 0, 16'd1,   32'h0,        0, 0, 0));
    // RESET mid-block and on the final sample
    vecs.push_back(mk(0, 1, 0, 2, 5,     1, 0, 16'd1,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 5,     1, 0, 16'd1,   32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2, 5,     1, 0, 16'd0,   32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0,     0, 0, 16'd0,   32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 9,     1, 0, 16'd0,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 9,     1, 0, 16'd0,   32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 9,     1, 0, 16'd0,   32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2, 9,     1, 0, 16'd0,   32'h0,        0, 0, 0));

    @(posedge SYSCLK);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].n, vecs[i].d, vecs[i].vld);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_avg, vecs[i].e_di,
                  vecs[i].e_addr, vecs[i].e_wrap, vecs[i].e_busy);
    end

    // n=0 with an 8-word RAM: nine writes land at 0..7,0 and the ninth sees WRAPPED
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 1, 0, 0, 16'(k * 100 + 7), 1);
      checkOutput($sformatf("wrap%0d", k), 1'b1, 16'(k * 100 + 7),
                  {16'(k * 100 + 7), 16'h0000}, 3'(k), (k == 8), 1'b0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("wrap_idle", 1'b0, 16'd807, 32'h0, 3'd1, 1'b1, 1'b0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("wrap_clear", 1'b0, 16'd807, 32'h0, 3'd0, 1'b0, 1'b0);

    // full-scale block: the wide accumulator must not overflow
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 0, 3, 16'hFFFF, 1);
      if (k == 6) checkOutput("full_7th", 1'b0, 16'd807, 32'h0, 3'd0, 1'b0, 1'b1);
      if (k == 7) checkOutput("full_8th", 1'b1, 16'hFFFF, 32'hFFFF0000, 3'd0, 1'b0, 1'b0);
    end

    // CFG_LOG2N=15 clamps to 8: one write after 256 samples
    for (int k = 0; k < 256; k++) begin
      applyStimulus(0, 1, 0, 15, 16'hFFFF, 1);
      if (k == 15) checkOutput("clamp_16th", 1'b0, 16'hFFFF, 32'h0, 3'd1, 1'b0, 1'b1);
      if (k == 254) checkOutput("clamp_255th", 1'b0, 16'hFFFF, 32'h0, 3'd1, 1'b0, 1'b1);
      if (k == 255) checkOutput("clamp_256th", 1'b1, 16'hFFFF, 32'hFFFF0000, 3'd1, 1'b0, 1'b0);
    end
    applyStimulus(0, 1, 0, 15, 0, 0);
    checkOutput("clamp_after", 1'b0, 16'hFFFF, 32'h0, 3'd2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
